arb_stream: RTL
===============

# arb_stream

Parametrised successor to the channel-block arbiter. Merges framed data blocks from `NCHAN` channel processors onto one GTP lane (`DW`-bit words plus a K-character flag) with round-robin fairness and a per-channel enable mask. Master-trigger K-words pre-empt data for the cycle they occupy. Over-length blocks are aborted with a dedicated K-word and counted. It sits between the `prc1chan` array and GTP lane 0 transmit.

## Interface
- `NCHAN`, 16, number of channel requesters (2..32)
- `DW`, 16, word width
- `MAXLEN`, 512, maximum words per block before forced abort (≥2)
- `IDLE_W`, 16'h50BC, idle comma word (K28.5 in low byte)
- `TRIG_W`, 16'h00FC, trigger K-word
- `ABRT_W`, 16'h00F7, abort K-word
- `ECNT_W`, 16, error counter width

- `clk` in 1 — CLK125 domain; all logic on rising edge
- `rst_n` in 1 — asynchronous, active-low reset
- `data` in NCHAN*DW — channel words, channel k at [DW*k+DW-1:DW*k]
- `req` in NCHAN — channel has a word of a block available
- `last` in NCHAN — current word of channel k is the final word of its block
- `mask` in NCHAN — 1 = channel eligible for grant
- `trigger` in 1 — single-cycle pulse, emit TRIG_W
- `ack` out NCHAN — word taken from channel this cycle (one-hot or zero)
- `dout` out DW — registered GTP word
- `kchar` out 1 — registered, 1 when `dout` is a K-word
- `err_cnt` out ECNT_W — saturating count of aborted blocks
- `busy` out 1 — state ≠ IDLE

## Operation
- States: IDLE, XFER, ABORT.
- IDLE: if any `req & mask`, select the first such index at or after `ptr`, with wrap. Latch it into `gnt` and go to XFER. This arbitration cycle emits idle.
- XFER: `ack[gnt] = req[gnt] & ~trigger`. Each ack cycle takes one word and increments `wcnt`.
  - `ack & last` → IDLE, `ptr <= gnt+1` (mod NCHAN), `wcnt <= 0`.
  - `ack & ~last` with `wcnt == MAXLEN-1` (the MAXLEN-th word) → ABORT.
  - `req[gnt]` low → stay in XFER and emit idle. `wcnt` counts words, not cycles.
- ABORT: when `trigger` is low, emit ABRT_W, increment `err_cnt` (saturating at all-ones), set `ptr <= gnt+1`, then go to IDLE. A trigger in that cycle delays ABORT by one cycle.
- Mask clearing for the granted channel mid-block has no effect until the block ends.
- Output register, priority order:
  1. `trigger` → TRIG_W, k=1
  2. ABORT emission → ABRT_W, k=1
  3. `ack` → `data[gnt]`, k=0
  4. otherwise IDLE_W, k=1
- Reset: state IDLE, `ptr` 0, `gnt` 0, `wcnt` 0, `err_cnt` 0, `dout` IDLE_W, `kchar` 1, `ack` 0, `busy` 0. Asserting reset mid-block drops the block silently, with no abort word.

## Timing
- `ack` is combinational from state, `req` and `trigger`. The channel advances its word on the edge where `ack` is high.
- Data latency: word taken at cycle t appears on `dout` at t+1.
- Trigger latency: pulse at t gives TRIG_W at t+1. Consecutive trigger cycles give consecutive TRIG_W words. The block resumes with the next word, and no data is lost.
- Minimum gap between blocks: 1 idle word, the IDLE arbitration cycle.
- A block of L words with no stalls or triggers takes L+1 cycles, IDLE to IDLE.
- `err_cnt` updates on the ABORT emission edge.

## Structure
- Shared package `arb_pkg`:
  - K-word constants IDLE_W, TRIG_W, ABRT_W
  - state encoding
  - `clog2` function for `ptr`, `gnt` and `wcnt` widths
- One sub-module `rr_pick`: combinational round-robin finder. Inputs are `NCHAN` request vector and `ptr`. Outputs are index and valid.

## Test plan
- Channels 3 and 7 each request a 4-word block with `ptr`=0 and mask all-ones. Required output: idle, ch3 words 0..3, idle, ch7 words 0..3. Each `ack` is asserted for exactly 4 cycles.
- Channels 0..15 are all requesting continuously. Over 16 blocks, grants come in order 0,1,…,15, then 0 again, so no channel is served twice before all others.
- `trigger` is pulsed on the 3rd word of a 6-word block. Required: `dout` = w0, w1, TRIG_W (k=1), w2, w3, w4, w5. `ack` is low in the trigger cycle.
- With MAXLEN=8, a channel never asserts `last`. Required: exactly 8 data words, then ABRT_W (k=1), `err_cnt` 0→1, and the grant moves to the next channel.
- `rst_n` is asserted low asynchronously mid-block. Required: `ack` and `busy` drop immediately, `dout`=IDLE_W with `kchar`=1. After release, the first grant goes to channel 0.
- `mask` = 16'h0001 with all channels requesting. Only channel 0 is ever acked.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the channel-block stream arbiter: default K-words,
// FSM state encoding and a constant-evaluable ceil(log2) helper.
package arb_pkg;

  localparam logic [15:0] IDLE_W = 16'h50BC;
  localparam logic [15:0] TRIG_W = 16'h00FC;
  localparam logic [15:0] ABRT_W = 16'h00F7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    ABORT = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first set request at or after ptr_i,
// wrapping modulo N.
module rr_pick #(
  parameter int N  = 16,
  parameter int PW = 4
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] idx_o,
  output logic          vld_o
);

  logic [PW:0] j;

  // Scan from the far end so the closest hit to ptr_i is written last.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    j     = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = {1'b0, ptr_i} + (PW+1)'(i);
      if (j >= (PW+1)'(N)) j = j - (PW+1)'(N);
      if (req_i[j[PW-1:0]]) begin
        idx_o = j[PW-1:0];
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_stream.sv
// Round-robin merge of framed channel blocks onto one GTP lane, with trigger
// pre-emption, per-channel mask and over-length block abort.
module arb_stream
  import arb_pkg::*;
#(
  parameter int              NCHAN  = 16,
  parameter int              DW     = 16,
  parameter int              MAXLEN = 512,
  parameter logic [DW-1:0]   IDLE_W = arb_pkg::IDLE_W,
  parameter logic [DW-1:0]   TRIG_W = arb_pkg::TRIG_W,
  parameter logic [DW-1:0]   ABRT_W = arb_pkg::ABRT_W,
  parameter int              ECNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NCHAN*DW-1:0] data_i,
  input  logic [NCHAN-1:0]    req_i,
  input  logic [NCHAN-1:0]    last_i,
  input  logic [NCHAN-1:0]    mask_i,
  input  logic                trigger_i,
  output logic [NCHAN-1:0]    ack_o,
  output logic [DW-1:0]       dout_o,
  output logic                kchar_o,
  output logic [ECNT_W-1:0]   err_cnt_o,
  output logic                busy_o
);

  localparam int PW  = clog2(NCHAN);
  localparam int WCW = clog2(MAXLEN);

  state_e             state_q, state_d;
  logic [PW-1:0]      ptr_q, ptr_d, gnt_q, gnt_d, nxt_ptr, pick_idx;
  logic [WCW-1:0]     wcnt_q, wcnt_d;
  logic [ECNT_W-1:0]  err_q, err_d;
  logic [DW-1:0]      dout_q, dout_d;
  logic               kchar_q, kchar_d;
  logic               pick_vld, take, abrt_emit;
  logic [DW-1:0]      words [NCHAN];

  for (genvar k = 0; k < NCHAN; k++) begin : g_words
    assign words[k] = data_i[k*DW +: DW];
  end

  rr_pick #(.N(NCHAN), .PW(PW)) u_pick (
    .req_i (req_i & mask_i),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .vld_o (pick_vld)
  );

  assign nxt_ptr = (gnt_q == PW'(NCHAN - 1)) ? '0 : gnt_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    wcnt_d    = wcnt_q;
    err_d     = err_q;
    take      = 1'b0;
    abrt_emit = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_idx;
          state_d = XFER;
        end
      end
      XFER: begin
        // The mask is deliberately ignored here so a block always completes.
        take = req_i[gnt_q] & ~trigger_i;
        if (take) begin
          if (last_i[gnt_q]) begin
            state_d = IDLE;
            ptr_d   = nxt_ptr;
            wcnt_d  = '0;
          end else if (wcnt_q == WCW'(MAXLEN - 1)) begin
            state_d = ABORT;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      ABORT: begin
        if (!trigger_i) begin
          abrt_emit = 1'b1;
          if (err_q != '1) err_d = err_q + 1'b1;
          ptr_d   = nxt_ptr;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ack_o = take ? ({{(NCHAN-1){1'b0}}, 1'b1} << gnt_q) : '0;

    if (trigger_i) begin
      dout_d  = TRIG_W;
      kchar_d = 1'b1;
    end else if (abrt_emit) begin
      dout_d  = ABRT_W;
      kchar_d = 1'b1;
    end else if (take) begin
      dout_d  = words[gnt_q];
      kchar_d = 1'b0;
    end else begin
      dout_d  = IDLE_W;
      kchar_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      wcnt_q  <= '0;
      err_q   <= '0;
      dout_q  <= IDLE_W;
      kchar_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
      kchar_q <= kchar_d;
    end
  end

  assign dout_o    = dout_q;
  assign kchar_o   = kchar_q;
  assign err_cnt_o = err_q;
  assign busy_o    = (state_q != IDLE);

endmodule
